// File: rtl/adrv9001_ctrl_pkg.sv
// Shared types and defaults for the ADRV9001 control-line sequencer.
//   rst_state_t : reset sequencer states
//   NUM_CH_DEF / CNT_W_DEF : default channel count and counter width
package adrv9001_ctrl_pkg;

  localparam int NUM_CH_DEF = 2;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_SETTLE = 2'd1,
    S_READY  = 2'd2
  } rst_state_t;

endpackage

// File: rtl/adrv9001_ctrl_sequencer_if.sv
// Control bus between the CPU register block (master) and the sequencer (slave).
//   reset_req               : single-cycle pulse restarting the reset sequence
//   tx_en_req / rx_en_req   : requested per-channel enable levels
//   adrv9001_rstn           : device reset, active low
//   adrv9001_tx_en / rx_en  : delayed per-channel enables driven to the pins
//   ready                   : reset sequence complete, enables live
//   pending                 : per line req!=out; [NUM_CH-1:0] TX, upper half RX
interface adrv9001_ctrl_sequencer_if #(
  parameter int NUM_CH = 2
);
  logic                  reset_req;
  logic [NUM_CH-1:0]     tx_en_req;
  logic [NUM_CH-1:0]     rx_en_req;
  logic                  adrv9001_rstn;
  logic [NUM_CH-1:0]     adrv9001_tx_en;
  logic [NUM_CH-1:0]     adrv9001_rx_en;
  logic                  ready;
  logic [2*NUM_CH-1:0]   pending;

  modport master (
    output reset_req, tx_en_req, rx_en_req,
    input  adrv9001_rstn, adrv9001_tx_en, adrv9001_rx_en, ready, pending
  );

  modport slave (
    input  reset_req, tx_en_req, rx_en_req,
    output adrv9001_rstn, adrv9001_tx_en, adrv9001_rx_en, ready, pending
  );
endinterface

// File: rtl/adrv9001_en_delay.sv
// One glitch-rejecting enable line.
//   clk, rst  : clock, synchronous active-high reset
//   req       : requested level
//   block     : holds off a rising transition (interlock); falls are never held
//   ready     : line enable; when low out and cnt are forced to 0
//   on_dly    : cycles of delay before a rise (latency on_dly+1)
//   off_dly   : cycles of delay before a fall (latency off_dly+1)
//   out       : registered line output
//   pending   : req differs from out while the line is live
module adrv9001_en_delay #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             block,
  input  logic             ready,
  input  logic [CNT_W-1:0] on_dly,
  input  logic [CNT_W-1:0] off_dly,
  output logic             out,
  output logic             pending
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] dly;

  assign dly     = req ? on_dly : off_dly;
  assign pending = ready & (req ^ out);

  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      out <= 1'b0;
      cnt <= '0;
    end else if (req == out || (req && block)) begin
      // req returned before the delay expired, or rise held off: drop progress
      cnt <= '0;
    end else if (cnt >= dly) begin
      // >= so a delay shortened below the running count fires on the next edge
      out <= req;
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/adrv9001_ctrl_sequencer.sv
// ADRV9001 reset sequencer and per-channel TX/RX enable delay lines.
//   clk, rst           : clock, synchronous active-high reset
//   cfg_rst_cycles     : rstn low time (0 treated as 1)
//   cfg_settle_cycles  : rstn release to ready (0 treated as 1)
//   cfg_on_dly         : shared enable rise delay
//   cfg_off_dly        : shared enable fall delay
//   bus                : control interface (slave side)
// Optional build macro ADRV9001_TDD_INTERLOCK_EN: TX and RX of a channel are
// never high together; TX wins a simultaneous rise.
module adrv9001_ctrl_sequencer
  import adrv9001_ctrl_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_rst_cycles,
  input  logic [CNT_W-1:0] cfg_settle_cycles,
  input  logic [CNT_W-1:0] cfg_on_dly,
  input  logic [CNT_W-1:0] cfg_off_dly,
  adrv9001_ctrl_sequencer_if.slave bus
);
  localparam int NL = 2 * NUM_CH;

  rst_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] tgt, tgt_nx;   // terminal count = max(cfg,1)-1, latched on entry
  logic [CNT_W-1:0] rst_m1, settle_m1;
  logic             rstn_q, ready_q, rstn_d, ready_d;
  logic             en_gate;

  logic [NL-1:0]    line_req, line_out, line_blk, line_pend;

  assign rst_m1    = (cfg_rst_cycles == '0)    ? '0 : cfg_rst_cycles - CNT_W'(1);
  assign settle_m1 = (cfg_settle_cycles == '0) ? '0 : cfg_settle_cycles - CNT_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RST;
      cnt    <= '0;
      tgt    <= rst_m1;
      rstn_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      tgt    <= tgt_nx;
      rstn_q <= rstn_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    tgt_nx   = tgt;
    case (state)
      S_RST: begin
        if (cnt >= tgt) begin
          state_nx = S_SETTLE;
          tgt_nx   = settle_m1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt >= tgt) state_nx = S_READY;
        else            cnt_nx   = cnt + CNT_W'(1);
      end
      default: ;
    endcase
    if (bus.reset_req) begin
      state_nx = S_RST;
      cnt_nx   = '0;
      tgt_nx   = rst_m1;
    end
  end

  // Outputs decoded from the next state so the pins come straight off flops
  always_comb begin
    rstn_d  = (state_nx != S_RST);
    ready_d = (state_nx == S_READY);
  end

  // Lines drop on the same edge that samples reset_req
  assign en_gate = ready_q & ~bus.reset_req;

  assign line_req = {bus.rx_en_req, bus.tx_en_req};

`ifdef ADRV9001_TDD_INTERLOCK_EN
  // RX also yields to a TX rise in progress, so TX wins a simultaneous request
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ilock
    assign line_blk[c]        = line_out[NUM_CH+c];
    assign line_blk[NUM_CH+c] = line_out[c] | line_req[c];
  end
`else
  assign line_blk = '0;
`endif

  for (genvar l = 0; l < NL; l++) begin : g_line
    adrv9001_en_delay #(.CNT_W(CNT_W)) u_line (
      .clk     (clk),
      .rst     (rst),
      .req     (line_req[l]),
      .block   (line_blk[l]),
      .ready   (en_gate),
      .on_dly  (cfg_on_dly),
      .off_dly (cfg_off_dly),
      .out     (line_out[l]),
      .pending (line_pend[l])
    );
  end

  assign bus.adrv9001_rstn  = rstn_q;
  assign bus.ready          = ready_q;
  assign bus.adrv9001_tx_en = line_out[NUM_CH-1:0];
  assign bus.adrv9001_rx_en = line_out[NL-1:NUM_CH];
  assign bus.pending        = line_pend;
endmodule
